// File: rtl/ex_operand_muldiv.sv
// EX-stage operand forwarding muxes plus an iterative multiply/divide unit
// with HI/LO result registers. One iteration per cycle, 32 iterations.
module ex_operand_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  EX_Forward_1,
  input  logic [1:0]  EX_Forward_2,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] ex_mem_result,
  input  logic [31:0] mem_wb_result,
  input  logic [2:0]  md_op,
  input  logic        md_valid,
  input  logic        flush,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {remainder, dividend bits shifting into quotient}.
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d; // negate product/quotient at the end
  logic        neg_rem_q, neg_rem_d; // negate remainder at the end
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod_fixed;

  // Operand forwarding muxes, purely combinational.
  always_comb begin
    case (EX_Forward_1)
      2'b01:   op_a = ex_mem_result;
      2'b10:   op_a = mem_wb_result;
      default: op_a = rs_data;
    endcase
    case (EX_Forward_2)
      2'b01:   op_b = ex_mem_result;
      2'b10:   op_b = mem_wb_result;
      default: op_b = rt_data;
    endcase
  end

  // Operand magnitudes and per-iteration datapath terms.
  assign signed_op = (md_op == OP_MULT) || (md_op == OP_DIV);
  assign a_mag     = (signed_op && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign b_mag     = (signed_op && op_b[31]) ? (~op_b + 32'd1) : op_b;
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign rem_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = rem_shift >= {1'b0, opnd_q};
  // The true difference is below the divisor, so 32 bits hold it exactly.
  assign div_diff  = acc_q[62:31] - opnd_q;
  assign prod_fixed = neg_res_q ? (~acc_q + 64'd1) : acc_q;

  // Next-state, iteration and result-write logic; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_valid) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                acc_d     = {32'd0, b_mag};
                opnd_d    = a_mag;
                is_div_d  = 1'b0;
                neg_res_d = signed_op && (op_a[31] ^ op_b[31]);
                neg_rem_d = 1'b0;
                div0_d    = 1'b0;
                cnt_d     = 6'd0;
                state_d   = RUN;
              end
              OP_DIV, OP_DIVU: begin
                acc_d     = {32'd0, a_mag};
                opnd_d    = b_mag;
                is_div_d  = 1'b1;
                neg_res_d = signed_op && (op_a[31] ^ op_b[31]);
                neg_rem_d = signed_op && op_a[31];
                div0_d    = (op_b == 32'd0);
                cnt_d     = 6'd0;
                state_d   = RUN;
              end
              OP_MTHI: hi_d = op_a;
              OP_MTLO: lo_d = op_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (is_div_q) begin
            acc_d = div_ge ? {div_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = DONE;
        end
        DONE: begin
          if (is_div_q) begin
            // Dividing by zero leaves |dividend| as remainder, so the sign
            // fix alone restores hi = dividend; only lo needs overriding.
            lo_d = div0_q ? 32'hFFFF_FFFF
                 : (neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
            hi_d = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
          end else begin
            hi_d = prod_fixed[63:32];
            lo_d = prod_fixed[31:0];
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign md_busy = (state_q != IDLE);

endmodule

// File: tb/tb_ex_operand_muldiv.sv
// Bench for ex_operand_muldiv: an arithmetic reference model checked against
// the DUT every cycle, plus directed cases with hand-computed results.
module tb_ex_operand_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  EX_Forward_1 = 2'b00;
  logic [1:0]  EX_Forward_2 = 2'b00;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic [31:0] ex_mem_result = 32'd0;
  logic [31:0] mem_wb_result = 32'd0;
  logic [2:0]  md_op = 3'd0;
  logic        md_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] op_a, op_b, hi, lo;
  logic        md_busy;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  ex_operand_muldiv dut (
    .clk(clk), .rst_n(rst_n),
    .EX_Forward_1(EX_Forward_1), .EX_Forward_2(EX_Forward_2),
    .rs_data(rs_data), .rt_data(rt_data),
    .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
    .md_op(md_op), .md_valid(md_valid), .flush(flush),
    .op_a(op_a), .op_b(op_b), .hi(hi), .lo(lo), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r,
                                      input logic [31:0] e, input logic [31:0] m);
    if (sel == 2'b01) return e;
    if (sel == 2'b10) return m;
    return r;
  endfunction

  // Returns {hi, lo} for a multiply/divide op using plain arithmetic.
  function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    int sa, sb, q, r;
    longint pa, pb;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa = a; sb = b;
    res = 64'd0;
    case (op)
      3'b001: begin pa = sa; pb = sb; res = pa * pb; end
      3'b010: begin ua = {32'd0, a}; ub = {32'd0, b}; res = ua * ub; end
      3'b011: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin q = sa / sb; r = sa % sb; res = {r, q}; end
      end
      3'b100: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  int          m_rem = 0;         // edges until the pending result lands
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] m_res = 64'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_hi <= 32'd0; m_lo <= 32'd0;
    end else if (flush) begin
      m_rem <= 0;
    end else if (m_rem != 0) begin
      if (m_rem == 1) begin m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; end
      m_rem <= m_rem - 1;
    end else if (md_valid) begin
      case (md_op)
        3'b001, 3'b010, 3'b011, 3'b100: begin
          m_res <= calc(md_op, fwd(EX_Forward_1, rs_data, ex_mem_result, mem_wb_result),
                               fwd(EX_Forward_2, rt_data, ex_mem_result, mem_wb_result));
          m_rem <= 33;  // accepted edge plus 33 more edges until write-back
        end
        3'b101: m_hi <= fwd(EX_Forward_1, rs_data, ex_mem_result, mem_wb_result);
        3'b110: m_lo <= fwd(EX_Forward_1, rs_data, ex_mem_result, mem_wb_result);
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_op_a", op_a, fwd(EX_Forward_1, rs_data, ex_mem_result, mem_wb_result));
      chk("cyc_op_b", op_b, fwd(EX_Forward_2, rt_data, ex_mem_result, mem_wb_result));
      chk("cyc_busy", md_busy, m_rem != 0);
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Issue one op from the register file, wait for completion, check result.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    EX_Forward_1 = 2'b00; EX_Forward_2 = 2'b00;
    rs_data = a; rt_data = b; md_op = op; md_valid = 1'b1;
    step();
    md_valid = 1'b0; md_op = 3'd0;
    n = 0;
    while (md_busy && n < 60) begin n++; step(); end
    // Busy spans edges N..N+33: observed high in the 33 cycles between them.
    chk({nm, "_busy_cycles"}, n, 33);
    chk({nm, "_hi"}, hi, ehi);
    chk({nm, "_lo"}, lo, elo);
    $display("op %s a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", nm, a, b, hi, lo, n);
  endtask

  initial begin
    logic [31:0] fexp [4];
    fexp[0] = 32'd1; fexp[1] = 32'd2; fexp[2] = 32'd3; fexp[3] = 32'd1;

    #2 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("reset_busy", md_busy, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);

    // Forwarding select walk
    rs_data = 32'd1; rt_data = 32'd11; ex_mem_result = 32'd2; mem_wb_result = 32'd3;
    for (int i = 0; i < 4; i++) begin
      EX_Forward_1 = 2'(i); EX_Forward_2 = 2'(i);
      #1;
      chk("fwd_op_a", op_a, fexp[i]);
      chk("fwd_op_b", op_b, (i == 0 || i == 3) ? 32'd11 : fexp[i]);
      $display("fwd sel=%0d op_a=%0d op_b=%0d", i, op_a, op_b);
    end
    step();

    run_op("mult_neg2x3",  3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7_2",     3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7_0",     3'b100, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_m7_0",     3'b011, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf",      3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("divu_100_7",   3'b100, 32'd100, 32'd7, 32'd2, 32'd14);

    // Ops 000 and 111 do nothing
    md_valid = 1'b1; md_op = 3'b000; step();
    md_op = 3'b111; step();
    md_valid = 1'b0;
    chk("nop_busy", md_busy, 0);
    chk("nop_lo", lo, 32'd14);
    $display("nop ops: hi=%h lo=%h", hi, lo);

    // MTLO, no busy cycle
    rs_data = 32'h1234; md_op = 3'b110; md_valid = 1'b1; step();
    md_valid = 1'b0;
    chk("mtlo_lo", lo, 32'h1234);
    chk("mtlo_busy", md_busy, 0);
    $display("mtlo lo=%h busy=%0d", lo, md_busy);

    // Second MULTU while busy is ignored
    begin
      int n;
      rs_data = 32'd3; rt_data = 32'd4; md_op = 3'b010; md_valid = 1'b1; step();
      rs_data = 32'd100; rt_data = 32'd100;
      for (int i = 0; i < 5; i++) step();
      md_valid = 1'b0;
      n = 0;
      while (md_busy && n < 60) begin n++; step(); end
      chk("ignore_busy_left", n, 28);
      chk("ignore_hi", hi, 0);
      chk("ignore_lo", lo, 12);
      $display("busy-ignore multu 3x4 -> hi=%h lo=%h", hi, lo);
    end

    // Flush at RUN count 10 with preloaded hi/lo
    rs_data = 32'hA; md_op = 3'b101; md_valid = 1'b1; step();
    rs_data = 32'hB; md_op = 3'b110; step();
    rs_data = 32'd7; rt_data = 32'd9; md_op = 3'b001; step();
    md_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("flush_pre_busy", md_busy, 1);
    flush = 1'b1; step();
    flush = 1'b0;
    chk("flush_busy", md_busy, 0);
    chk("flush_hi", hi, 32'hA);
    chk("flush_lo", lo, 32'hB);
    $display("flush at count 10 -> busy=%0d hi=%h lo=%h", md_busy, hi, lo);

    // Flush wins over a start in IDLE
    flush = 1'b1; md_valid = 1'b1; md_op = 3'b010; step();
    flush = 1'b0; md_valid = 1'b0;
    chk("flush_start_busy", md_busy, 0);
    $display("flush+valid in idle -> busy=%0d", md_busy);

    // Reset mid-DIV
    rs_data = 32'd100; rt_data = 32'd7; md_op = 3'b011; md_valid = 1'b1; step();
    md_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", md_busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    $display("reset mid-div -> busy=%0d hi=%h lo=%h", md_busy, hi, lo);
    step();
    rst_n = 1'b1;
    run_op("multu_5x6", 3'b010, 32'd5, 32'd6, 32'd0, 32'd30);

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
